// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared widths, mode encoding and saturation bounds for the MAC array
// Purpose: common definitions for mac_pe and sat_add.
// Contents:
//   DATA_W_DEF / ACC_W_DEF  default activation/weight and accumulator widths
//   mode_e                  MODE_WS (weight-stationary) / MODE_OS (output-stationary)
//   sat_max / sat_min       signed bounds of a w-bit value, returned in 64 bits (w <= 64)
package tpu_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ACC_W_DEF  = 2 * DATA_W_DEF;

  typedef enum logic {
    MODE_WS = 1'b0,
    MODE_OS = 1'b1
  } mode_e;

  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Two's complement of -(2^(w-1)) is the bitwise inverse of the positive bound.
  function automatic logic [63:0] sat_min(input int w);
    return ~sat_max(w);
  endfunction

endpackage

// File: rtl/sat_add.sv
// rtl/sat_add.sv - signed W-bit adder that clamps to the signed range on overflow
// Purpose: saturating signed addition shared by the WS partial sum and the OS accumulator.
// Ports:
//   i_a, i_b  in  W  signed operands
//   o_sum     out W  i_a + i_b, clamped to [sat_min(W), sat_max(W)]
//   o_ovf     out 1  the result was clamped
module sat_add
  import tpu_pkg::*;
#(
  parameter int W = ACC_W_DEF
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum,
  output logic         o_ovf
);

  localparam logic [63:0]  HI64 = sat_max(W);
  localparam logic [63:0]  LO64 = sat_min(W);
  localparam logic [W-1:0] HI   = HI64[W-1:0];
  localparam logic [W-1:0] LO   = LO64[W-1:0];

  logic [W:0] w_sum;

  assign w_sum = {i_a[W-1], i_a} + {i_b[W-1], i_b};
  // The extra sign bit disagrees with the MSB only when the true sum left the range;
  // the extra bit itself gives the direction of the overflow.
  assign o_ovf = w_sum[W] ^ w_sum[W-1];
  assign o_sum = !o_ovf ? w_sum[W-1:0] : (w_sum[W] ? LO : HI);

endmodule

// File: rtl/mac_pe.sv
// rtl/mac_pe.sv - systolic MAC processing element, weight- or output-stationary
// Purpose: one cell of the N x M MAC matrix. Activations flow west->east, partial sums
//   north->south, weights shift down the column through a double-buffered chain.
// Ports:
//   i_clk, i_rst_n                    clock, asynchronous active-low reset
//   i_cfg_mode                        0 = WS, 1 = OS (takes effect the same cycle)
//   i_w_in_valid/i_w_in               weight chain shift strobe/data from the north
//   o_w_out_valid/o_w_out             weight chain to the south (old shadow)
//   i_w_commit                        copy shadow weight into active weight
//   i_act_in_valid/i_act_in           activation from the west
//   o_act_out_valid/o_act_out         registered activation to the east
//   i_psum_in_valid/i_psum_in         partial sum from the north
//   o_psum_out_valid/o_psum_out       partial sum to the south
//   i_acc_clear, i_drain              OS: start a new tile / emit the accumulator
//   o_sat_flag, o_err_overrun         sticky saturation / skid overflow flags
module mac_pe
  import tpu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cfg_mode,
  input  logic              i_w_in_valid,
  input  logic [DATA_W-1:0] i_w_in,
  output logic              o_w_out_valid,
  output logic [DATA_W-1:0] o_w_out,
  input  logic              i_w_commit,
  input  logic              i_act_in_valid,
  input  logic [DATA_W-1:0] i_act_in,
  output logic              o_act_out_valid,
  output logic [DATA_W-1:0] o_act_out,
  input  logic              i_psum_in_valid,
  input  logic [ACC_W-1:0]  i_psum_in,
  output logic              o_psum_out_valid,
  output logic [ACC_W-1:0]  o_psum_out,
  input  logic              i_acc_clear,
  input  logic              i_drain,
  output logic              o_sat_flag,
  output logic              o_err_overrun
);

  localparam int PW = 2 * DATA_W;

  logic [DATA_W-1:0] r_shadow, r_weight, r_w_out, r_act_out;
  logic              r_shadow_v, r_w_out_valid, r_act_out_valid;
  logic [ACC_W-1:0]  r_acc, r_skid, r_psum_out;
  logic              r_skid_v, r_psum_out_valid, r_sat, r_ovr;

  mode_e             w_mode;
  logic [PW-1:0]     w_prod_n;
  logic [ACC_W-1:0]  w_prod, w_ws_b, w_ws_sum, w_os_sum;
  logic              w_ws_ovf, w_os_ovf;
  logic [ACC_W-1:0]  w_psum_nxt, w_skid_nxt, w_acc_nxt;
  logic              w_psum_v_nxt, w_skid_v_nxt, w_sat_set, w_sat_clr, w_ovr_set;

  assign w_mode   = mode_e'(i_cfg_mode);
  assign w_prod_n = $signed(i_act_in) * $signed(r_weight);
  assign w_prod   = ACC_W'($signed(w_prod_n));
  assign w_ws_b   = i_psum_in_valid ? i_psum_in : '0;

  sat_add #(.W(ACC_W)) u_ws_add (.i_a(w_prod), .i_b(w_ws_b),  .o_sum(w_ws_sum), .o_ovf(w_ws_ovf));
  sat_add #(.W(ACC_W)) u_os_add (.i_a(r_acc),  .i_b(w_prod),  .o_sum(w_os_sum), .o_ovf(w_os_ovf));

  // Output-slot arbitration: a WS product or an OS drain owns the slot; otherwise the
  // skid word (oldest) goes first, and a passing psum_in takes its place in the skid.
  always_comb begin
    w_psum_nxt   = r_psum_out;
    w_psum_v_nxt = 1'b0;
    w_skid_nxt   = r_skid;
    w_skid_v_nxt = r_skid_v;
    w_acc_nxt    = r_acc;
    w_sat_set    = 1'b0;
    w_sat_clr    = 1'b0;
    w_ovr_set    = 1'b0;

    if (w_mode == MODE_WS && i_act_in_valid) begin
      w_psum_nxt   = w_ws_sum;
      w_psum_v_nxt = 1'b1;
      w_sat_set    = w_ws_ovf;
    end else if (w_mode == MODE_OS && i_drain) begin
      w_psum_nxt   = r_acc;
      w_psum_v_nxt = 1'b1;
      if (i_psum_in_valid) begin
        if (r_skid_v) begin
          w_ovr_set = 1'b1;
        end else begin
          w_skid_nxt   = i_psum_in;
          w_skid_v_nxt = 1'b1;
        end
      end
    end else if (i_psum_in_valid) begin
      w_psum_v_nxt = 1'b1;
      if (r_skid_v) begin
        w_psum_nxt = r_skid;
        w_skid_nxt = i_psum_in;
      end else begin
        w_psum_nxt = i_psum_in;
      end
    end else if (r_skid_v) begin
      w_psum_nxt   = r_skid;
      w_psum_v_nxt = 1'b1;
      w_skid_v_nxt = 1'b0;
    end

    if (w_mode == MODE_OS) begin
      if (i_acc_clear || i_drain) begin
        w_acc_nxt = i_act_in_valid ? w_prod : '0;
        w_sat_clr = i_acc_clear;
      end else if (i_act_in_valid) begin
        w_acc_nxt = w_os_sum;
        w_sat_set = w_os_ovf;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shadow         <= '0;
      r_shadow_v       <= 1'b0;
      r_weight         <= '0;
      r_w_out          <= '0;
      r_w_out_valid    <= 1'b0;
      r_act_out        <= '0;
      r_act_out_valid  <= 1'b0;
      r_acc            <= '0;
      r_skid           <= '0;
      r_skid_v         <= 1'b0;
      r_psum_out       <= '0;
      r_psum_out_valid <= 1'b0;
      r_sat            <= 1'b0;
      r_ovr            <= 1'b0;
    end else begin
      r_w_out_valid <= 1'b0;
      if (i_w_in_valid) begin
        r_shadow      <= i_w_in;
        r_shadow_v    <= 1'b1;
        r_w_out       <= r_shadow;
        r_w_out_valid <= r_shadow_v;
      end
      // Reads the pre-shift shadow, so commit and shift may share a cycle.
      if (i_w_commit && r_shadow_v) r_weight <= r_shadow;

      r_act_out_valid <= i_act_in_valid;
      if (i_act_in_valid) r_act_out <= i_act_in;

      r_acc            <= w_acc_nxt;
      r_skid           <= w_skid_nxt;
      r_skid_v         <= w_skid_v_nxt;
      r_psum_out       <= w_psum_nxt;
      r_psum_out_valid <= w_psum_v_nxt;

      if (w_sat_clr)      r_sat <= 1'b0;
      else if (w_sat_set) r_sat <= 1'b1;
      if (w_ovr_set)      r_ovr <= 1'b1;
    end
  end

  assign o_w_out_valid    = r_w_out_valid;
  assign o_w_out          = r_w_out;
  assign o_act_out_valid  = r_act_out_valid;
  assign o_act_out        = r_act_out;
  assign o_psum_out_valid = r_psum_out_valid;
  assign o_psum_out       = r_psum_out;
  assign o_sat_flag       = r_sat;
  assign o_err_overrun    = r_ovr;

endmodule

// File: tb/tb_mac_pe.sv
// tb/tb_mac_pe.sv - directed self-checking bench for mac_pe (DATA_W=8, ACC_W=16)
module tb_mac_pe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_mode;
  logic        w_in_valid;
  logic [7:0]  w_in;
  logic        w_out_valid;
  logic [7:0]  w_out;
  logic        w_commit;
  logic        act_in_valid;
  logic [7:0]  act_in;
  logic        act_out_valid;
  logic [7:0]  act_out;
  logic        psum_in_valid;
  logic [15:0] psum_in;
  logic        psum_out_valid;
  logic [15:0] psum_out;
  logic        acc_clear;
  logic        drain;
  logic        sat_flag;
  logic        err_overrun;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mac_pe #(.DATA_W(8), .ACC_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cfg_mode(cfg_mode),
    .i_w_in_valid(w_in_valid), .i_w_in(w_in),
    .o_w_out_valid(w_out_valid), .o_w_out(w_out), .i_w_commit(w_commit),
    .i_act_in_valid(act_in_valid), .i_act_in(act_in),
    .o_act_out_valid(act_out_valid), .o_act_out(act_out),
    .i_psum_in_valid(psum_in_valid), .i_psum_in(psum_in),
    .o_psum_out_valid(psum_out_valid), .o_psum_out(psum_out),
    .i_acc_clear(acc_clear), .i_drain(drain),
    .o_sat_flag(sat_flag), .o_err_overrun(err_overrun)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    w_in_valid = 0; w_in = 0; w_commit = 0;
    act_in_valid = 0; act_in = 0; psum_in_valid = 0; psum_in = 0;
    acc_clear = 0; drain = 0;
  endtask

  task automatic load_weight(input logic [7:0] w);
    idle_inputs();
    w_in_valid = 1; w_in = w;
    step();
    w_in_valid = 0; w_commit = 1;
    step();
    idle_inputs();
  endtask

  task automatic test_reset();
    rst_n = 0;
    cfg_mode = 0;
    for (int i = 0; i < 4; i++) begin
      w_in_valid = 1'($urandom); w_in = 8'($urandom); w_commit = 1'($urandom);
      act_in_valid = 1'($urandom); act_in = 8'($urandom);
      psum_in_valid = 1'($urandom); psum_in = 16'($urandom);
      acc_clear = 1'($urandom); drain = 1'($urandom); cfg_mode = 1'($urandom);
      step();
    end
    n_checks++;
    if ({w_out_valid, w_out, act_out_valid, act_out} !== 18'd0) begin
      n_fail++; $display("FAIL reset_w_act got %h exp 0", {w_out_valid, w_out, act_out_valid, act_out});
    end
    n_checks++;
    if ({psum_out_valid, psum_out} !== 17'd0) begin
      n_fail++; $display("FAIL reset_psum got %h exp 0", {psum_out_valid, psum_out});
    end
    n_checks++;
    if ({sat_flag, err_overrun} !== 2'b00) begin
      n_fail++; $display("FAIL reset_flags got %b exp 00", {sat_flag, err_overrun});
    end
    idle_inputs();
    cfg_mode = 0;
    rst_n = 1;
    step();
    // commit with an empty shadow must leave weight at 0
    w_commit = 1;
    step();
    w_commit = 0; act_in_valid = 1; act_in = 8'd3;
    step();
    n_checks++;
    if (psum_out_valid !== 1'b1 || psum_out !== 16'd0) begin
      n_fail++; $display("FAIL commit_ignored got v=%b %0d exp v=1 0", psum_out_valid, $signed(psum_out));
    end
    idle_inputs();
  endtask

  task automatic test_weight_chain();
    w_in_valid = 1; w_in = 8'd3;
    step();
    n_checks++;
    if (w_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL chain_first_valid got %b exp 0", w_out_valid);
    end
    w_in = 8'd5;
    step();
    n_checks++;
    if (w_out_valid !== 1'b1 || w_out !== 8'd3) begin
      n_fail++; $display("FAIL chain_w_out got v=%b %0d exp v=1 3", w_out_valid, w_out);
    end
    w_in_valid = 0; w_commit = 1;
    step();
    n_checks++;
    if (w_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL chain_idle_valid got %b exp 0", w_out_valid);
    end
    w_commit = 0; act_in_valid = 1; act_in = 8'd4; psum_in_valid = 1; psum_in = 16'd10;
    step();
    n_checks++;
    if (psum_out_valid !== 1'b1 || psum_out !== 16'd30) begin
      n_fail++; $display("FAIL ws_sum got v=%b %0d exp v=1 30", psum_out_valid, $signed(psum_out));
    end
    n_checks++;
    if (act_out_valid !== 1'b1 || act_out !== 8'd4) begin
      n_fail++; $display("FAIL act_out got v=%b %0d exp v=1 4", act_out_valid, act_out);
    end
    idle_inputs();
    step();
    n_checks++;
    if (act_out_valid !== 1'b0 || act_out !== 8'd4 || psum_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL act_hold got av=%b a=%0d pv=%b exp 0 4 0", act_out_valid, act_out, psum_out_valid);
    end
  endtask

  task automatic test_ws_saturation();
    load_weight(8'd127);
    act_in_valid = 1; act_in = 8'd127; psum_in_valid = 1; psum_in = 16'd32000;
    step();
    n_checks++;
    if (psum_out !== 16'h7FFF || sat_flag !== 1'b1) begin
      n_fail++; $display("FAIL ws_sat_pos got %0d sat=%b exp 32767 sat=1", $signed(psum_out), sat_flag);
    end
    load_weight(8'h80);
    act_in_valid = 1; act_in = 8'd127; psum_in_valid = 1; psum_in = 16'h8000;
    step();
    n_checks++;
    if (psum_out !== 16'h8000) begin
      n_fail++; $display("FAIL ws_sat_neg got %0d exp -32768", $signed(psum_out));
    end
    psum_in_valid = 0; psum_in = 16'd999; act_in = 8'd2;
    step();
    n_checks++;
    if (psum_out !== 16'hFF00) begin
      n_fail++; $display("FAIL ws_no_psum got %0d exp -256", $signed(psum_out));
    end
    act_in_valid = 0; psum_in_valid = 1; psum_in = 16'd55;
    step();
    n_checks++;
    if (psum_out_valid !== 1'b1 || psum_out !== 16'd55 || sat_flag !== 1'b1) begin
      n_fail++; $display("FAIL ws_pass got v=%b %0d sat=%b exp v=1 55 sat=1", psum_out_valid, $signed(psum_out), sat_flag);
    end
    idle_inputs();
  endtask

  task automatic test_os_accumulate();
    cfg_mode = 1;
    load_weight(8'd2);
    acc_clear = 1;
    step();
    n_checks++;
    if (sat_flag !== 1'b0) begin
      n_fail++; $display("FAIL os_clear_sat got %b exp 0", sat_flag);
    end
    acc_clear = 0; act_in_valid = 1;
    act_in = 8'd1; step();
    n_checks++;
    if (psum_out_valid !== 1'b0) begin
      n_fail++; $display("FAIL os_quiet got %b exp 0", psum_out_valid);
    end
    act_in = 8'd2; step();
    act_in = 8'd3; step();
    act_in_valid = 0; drain = 1;
    step();
    n_checks++;
    if (psum_out_valid !== 1'b1 || psum_out !== 16'd12) begin
      n_fail++; $display("FAIL os_drain got v=%b %0d exp v=1 12", psum_out_valid, $signed(psum_out));
    end
    step();
    n_checks++;
    if (psum_out_valid !== 1'b1 || psum_out !== 16'd0) begin
      n_fail++; $display("FAIL os_after_drain got v=%b %0d exp v=1 0", psum_out_valid, $signed(psum_out));
    end
    // accumulator clamp: 16129 -> 32258 -> clamp at 32767
    load_weight(8'd127);
    acc_clear = 1; act_in_valid = 1; act_in = 8'd127;
    step();
    acc_clear = 0;
    step();
    step();
    act_in_valid = 0; drain = 1;
    step();
    n_checks++;
    if (psum_out !== 16'h7FFF || sat_flag !== 1'b1) begin
      n_fail++; $display("FAIL os_sat got %0d sat=%b exp 32767 sat=1", $signed(psum_out), sat_flag);
    end
    idle_inputs();
  endtask

  task automatic test_os_collision();
    load_weight(8'd2);
    acc_clear = 1; act_in_valid = 1; act_in = 8'd5;
    step();
    acc_clear = 0; act_in_valid = 0; drain = 1; psum_in_valid = 1; psum_in = 16'd7;
    step();
    n_checks++;
    if (psum_out_valid !== 1'b1 || psum_out !== 16'd10) begin
      n_fail++; $display("FAIL coll_acc got v=%b %0d exp v=1 10", psum_out_valid, $signed(psum_out));
    end
    idle_inputs();
    step();
    n_checks++;
    if (psum_out_valid !== 1'b1 || psum_out !== 16'd7) begin
      n_fail++; $display("FAIL coll_skid got v=%b %0d exp v=1 7", psum_out_valid, $signed(psum_out));
    end
    step();
    n_checks++;
    if (psum_out_valid !== 1'b0 || err_overrun !== 1'b0) begin
      n_fail++; $display("FAIL coll_empty got v=%b ovr=%b exp 0 0", psum_out_valid, err_overrun);
    end
    // full skid drains ahead of a passing psum, which then takes its slot
    drain = 1; psum_in_valid = 1; psum_in = 16'd40;
    step();
    drain = 0; psum_in = 16'd50;
    step();
    n_checks++;
    if (psum_out_valid !== 1'b1 || psum_out !== 16'd40) begin
      n_fail++; $display("FAIL skid_first got v=%b %0d exp v=1 40", psum_out_valid, $signed(psum_out));
    end
    idle_inputs();
    step();
    n_checks++;
    if (psum_out_valid !== 1'b1 || psum_out !== 16'd50) begin
      n_fail++; $display("FAIL skid_refill got v=%b %0d exp v=1 50", psum_out_valid, $signed(psum_out));
    end
    step();
    // back-to-back collisions overflow the skid; the newer word (30) is dropped
    acc_clear = 1; act_in_valid = 1; act_in = 8'd1;
    step();
    acc_clear = 0; act_in_valid = 0; drain = 1; psum_in_valid = 1; psum_in = 16'd20;
    step();
    n_checks++;
    if (psum_out !== 16'd2 || err_overrun !== 1'b0) begin
      n_fail++; $display("FAIL ovr_first got %0d ovr=%b exp 2 0", $signed(psum_out), err_overrun);
    end
    psum_in = 16'd30;
    step();
    n_checks++;
    if (psum_out !== 16'd0 || err_overrun !== 1'b1) begin
      n_fail++; $display("FAIL ovr_set got %0d ovr=%b exp 0 1", $signed(psum_out), err_overrun);
    end
    idle_inputs();
    step();
    n_checks++;
    if (psum_out_valid !== 1'b1 || psum_out !== 16'd20) begin
      n_fail++; $display("FAIL ovr_kept got v=%b %0d exp v=1 20", psum_out_valid, $signed(psum_out));
    end
    step();
    n_checks++;
    if (psum_out_valid !== 1'b0 || err_overrun !== 1'b1) begin
      n_fail++; $display("FAIL ovr_sticky got v=%b ovr=%b exp 0 1", psum_out_valid, err_overrun);
    end
  endtask

  task automatic test_mid_reset();
    load_weight(8'd127);
    acc_clear = 1; act_in_valid = 1; act_in = 8'd127;
    step();
    acc_clear = 0;
    step();
    step();
    act_in = 8'd3;
    step();
    n_checks++;
    if (sat_flag !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset_sat got %b exp 1", sat_flag);
    end
    rst_n = 0;
    #2;
    n_checks++;
    if ({sat_flag, err_overrun, psum_out_valid, act_out_valid} !== 4'b0000) begin
      n_fail++; $display("FAIL async_reset got %b exp 0000", {sat_flag, err_overrun, psum_out_valid, act_out_valid});
    end
    #1;
    idle_inputs();
    rst_n = 1;
    step();
    load_weight(8'd3);
    act_in_valid = 1; act_in = 8'd4;
    step();
    act_in_valid = 0; drain = 1;
    step();
    n_checks++;
    if (psum_out_valid !== 1'b1 || psum_out !== 16'd12) begin
      n_fail++; $display("FAIL post_reset_acc got v=%b %0d exp v=1 12", psum_out_valid, $signed(psum_out));
    end
    n_checks++;
    if ({sat_flag, err_overrun} !== 2'b00) begin
      n_fail++; $display("FAIL post_reset_flags got %b exp 00", {sat_flag, err_overrun});
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    cfg_mode = 0;
    test_reset();
    test_weight_chain();
    test_ws_saturation();
    test_os_accumulate();
    test_os_collision();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
